hazard_detection_unit: RTL and testbench

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

---
 rtl/hazard_detection_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_detection_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for a 5-stage MIPS-style pipeline.
//
// Detects load-use hazards, branch operand hazards (branches resolve in ID)
// and accesses to a busy multiply/divide unit, and produces the pipeline
// control for a one-cycle stall. Also tracks multiply/divide occupancy and
// keeps a saturating count of stalled cycles.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   IFID_Rs, IFID_Rt           source registers of the ID instruction
//   ID_UsesRt                  ID instruction reads Rt
//   ID_IsBranch                ID instruction is beq/bne
//   ID_MduStart                ID instruction is mult/multu/div/divu
//   ID_UsesHiLo                ID instruction is mfhi/mflo/mthi/mtlo
//   BranchTaken                ID branch/jump redirects the PC this cycle
//   IDEX_Rd/RegWrite/MemRead   EX-stage destination and control bits
//   EXMEM_Rd/MemRead           MEM-stage destination and load flag
//   PCWrite, IFID_Write        PC and IF/ID enables (combinational)
//   IFID_Flush, IDEX_Bubble    IF/ID clear, ID/EX control squash (combinational)
//   MduBusy                    multiply/divide unit occupied (registered)
//   StallCycles                saturating stalled-cycle count (registered)

module hazard_detection_unit #(
    parameter int unsigned MDU_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        ID_UsesRt,
    input  logic        ID_IsBranch,
    input  logic        ID_MduStart,
    input  logic        ID_UsesHiLo,
    input  logic        BranchTaken,
    input  logic [4:0]  IDEX_Rd,
    input  logic        IDEX_RegWrite,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  EXMEM_Rd,
    input  logic        EXMEM_MemRead,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MduBusy,
    output logic [15:0] StallCycles
);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } mdu_state_e;

    // Counter holds the number of busy cycles still to come after the current
    // one, so the unit reports busy for exactly MDU_LATENCY cycles.
    localparam logic [7:0] CntLoad = 8'(MDU_LATENCY - 1);

    mdu_state_e  r_state;
    mdu_state_e  w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [15:0] r_stall_cnt;

    logic w_match_ex;
    logic w_match_mem;
    logic w_load_use;
    logic w_branch_hz;
    logic w_mdu_hz;
    logic w_stall;

    // Register $0 is hard-wired to zero and never creates a dependency.
    function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign w_match_ex  = f_match(IDEX_Rd, IFID_Rs, IFID_Rt, ID_UsesRt);
    assign w_match_mem = f_match(EXMEM_Rd, IFID_Rs, IFID_Rt, ID_UsesRt);

    assign w_load_use  = IDEX_MemRead && w_match_ex;
    assign w_branch_hz = ID_IsBranch &&
                         ((IDEX_RegWrite && w_match_ex) || (EXMEM_MemRead && w_match_mem));
    assign w_mdu_hz    = MduBusy && (ID_UsesHiLo || ID_MduStart);
    assign w_stall     = w_load_use || w_branch_hz || w_mdu_hz;

    // Pipeline control; a stall holds the branch in ID, so its redirect
    // (and flush) is deferred until the hazard clears.
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = BranchTaken;
        if (w_stall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b0;
        end
    end

    // MDU occupancy FSM next state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (ID_MduStart && !w_stall) begin
                    w_state_next = StBusy;
                    w_cnt_next   = CntLoad;
                end
            end
            StBusy: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign MduBusy     = (r_state == StBusy);
    assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit (MDU_LATENCY = 4).
// Directed scenarios plus randomized stimulus against a behavioural model
// that tracks remaining MDU busy cycles and the stall count as integers.

module tb_hazard_detection_unit;

    localparam int unsigned Lat = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rd, EXMEM_Rd;
    logic        ID_UsesRt, ID_IsBranch, ID_MduStart, ID_UsesHiLo, BranchTaken;
    logic        IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, MduBusy;
    logic [15:0] StallCycles;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_rem = 0;  // busy cycles remaining, counting the current one
    int m_cnt = 0;  // stalled cycles, saturating

    always #5 clk = ~clk;

    hazard_detection_unit #(.MDU_LATENCY(Lat)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .ID_IsBranch  (ID_IsBranch),
        .ID_MduStart  (ID_MduStart),
        .ID_UsesHiLo  (ID_UsesHiLo),
        .BranchTaken  (BranchTaken),
        .IDEX_Rd      (IDEX_Rd),
        .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_MemRead (IDEX_MemRead),
        .EXMEM_Rd     (EXMEM_Rd),
        .EXMEM_MemRead(EXMEM_MemRead),
        .PCWrite      (PCWrite),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Bubble  (IDEX_Bubble),
        .MduBusy      (MduBusy),
        .StallCycles  (StallCycles)
    );

    function automatic bit f_match(logic [4:0] r);
        return (r != 0) && (r == IFID_Rs || (ID_UsesRt && r == IFID_Rt));
    endfunction

    function automatic bit f_stall();
        bit lu, br, md;
        lu = IDEX_MemRead && f_match(IDEX_Rd);
        br = ID_IsBranch && ((IDEX_RegWrite && f_match(IDEX_Rd)) ||
                             (EXMEM_MemRead && f_match(EXMEM_Rd)));
        md = (m_rem > 0) && (ID_UsesHiLo || ID_MduStart);
        return lu || br || md;
    endfunction

    always @(posedge clk) begin : model_update
        bit s;
        s = f_stall();
        if (!rst_n) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (ID_MduStart && !s) m_rem = Lat;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IFID_Rs = 0; IFID_Rt = 0; IDEX_Rd = 0; EXMEM_Rd = 0;
        ID_UsesRt = 0; ID_IsBranch = 0; ID_MduStart = 0; ID_UsesHiLo = 0;
        BranchTaken = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0; EXMEM_MemRead = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks += 4;
        if (MduBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", MduBusy); end
        if (StallCycles !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", StallCycles); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL reset_pcwrite got=%b exp=1", PCWrite); end
        if (IDEX_Bubble !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=0", IDEX_Bubble); end
        BranchTaken = 1'b1;
        #1;
        checks++;
        if (IFID_Flush !== 1'b1) begin failures++; $display("FAIL reset_flush got=%b exp=1", IFID_Flush); end
        next_cycle();
        rst_n = 1'b1;
        BranchTaken = 1'b0;
    endtask

    task automatic test_load_use();
        clear_inputs();
        IDEX_MemRead = 1; IDEX_Rd = 8; IFID_Rs = 8;
        @(negedge clk);
        checks += 4;
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL lu_pcwrite got=%b exp=0", PCWrite); end
        if (IFID_Write !== 1'b0) begin failures++; $display("FAIL lu_ifidwrite got=%b exp=0", IFID_Write); end
        if (IDEX_Bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%b exp=1", IDEX_Bubble); end
        if (StallCycles !== 16'd0) begin failures++; $display("FAIL lu_count_before got=%0d exp=0", StallCycles); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks += 2;
        if (StallCycles !== 16'd1) begin failures++; $display("FAIL lu_count_after got=%0d exp=1", StallCycles); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL lu_cleared got=%b exp=1", PCWrite); end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        IDEX_MemRead = 1; IDEX_Rd = 0; IFID_Rs = 0;
        @(negedge clk);
        checks += 2;
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL zero_pcwrite got=%b exp=1", PCWrite); end
        if (IDEX_Bubble !== 1'b0) begin failures++; $display("FAIL zero_bubble got=%b exp=0", IDEX_Bubble); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (StallCycles !== 16'd1) begin failures++; $display("FAIL zero_count got=%0d exp=1", StallCycles); end
        next_cycle();
    endtask

    task automatic test_branch();
        clear_inputs();
        ID_IsBranch = 1; EXMEM_MemRead = 1; EXMEM_Rd = 9; IFID_Rt = 9; ID_UsesRt = 1;
        BranchTaken = 1;
        @(negedge clk);
        checks += 2;
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL br_stall got=%b exp=0", PCWrite); end
        if (IFID_Flush !== 1'b0) begin failures++; $display("FAIL br_flush_stalled got=%b exp=0", IFID_Flush); end
        next_cycle();
        EXMEM_MemRead = 0;
        @(negedge clk);
        checks += 3;
        if (IFID_Flush !== 1'b1) begin failures++; $display("FAIL br_flush_clear got=%b exp=1", IFID_Flush); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL br_pcwrite_clear got=%b exp=1", PCWrite); end
        if (StallCycles !== 16'd2) begin failures++; $display("FAIL br_count got=%0d exp=2", StallCycles); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mdu();
        int busy = 0;
        int stalls = 0;
        int base;
        clear_inputs();
        ID_MduStart = 1;
        @(negedge clk);
        checks += 2;
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL mdu_start_stall got=%b exp=1", PCWrite); end
        if (MduBusy !== 1'b0) begin failures++; $display("FAIL mdu_start_busy got=%b exp=0", MduBusy); end
        base = int'(StallCycles);
        next_cycle();
        ID_MduStart = 0;
        ID_UsesHiLo = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!MduBusy) break;
            busy++;
            if (!PCWrite) stalls++;
            next_cycle();
        end
        checks += 5;
        if (busy != Lat) begin failures++; $display("FAIL mdu_busy_len got=%0d exp=%0d", busy, Lat); end
        if (stalls != Lat) begin failures++; $display("FAIL mdu_stalls got=%0d exp=%0d", stalls, Lat); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL mdu_after_stall got=%b exp=1", PCWrite); end
        if (MduBusy !== 1'b0) begin failures++; $display("FAIL mdu_after_busy got=%b exp=0", MduBusy); end
        if (int'(StallCycles) != base + Lat) begin
            failures++; $display("FAIL mdu_count got=%0d exp=%0d", StallCycles, base + Lat);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int busy = 0;
        int stalls = 0;
        clear_inputs();
        ID_MduStart = 1;  // held for the whole scenario
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!MduBusy) break;
            busy++;
            if (!PCWrite) stalls++;
            next_cycle();
        end
        checks += 4;
        if (busy != Lat) begin failures++; $display("FAIL b2b_busy_len got=%0d exp=%0d", busy, Lat); end
        if (stalls != Lat) begin failures++; $display("FAIL b2b_stalls got=%0d exp=%0d", stalls, Lat); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", PCWrite); end
        next_cycle();
        @(negedge clk);
        if (MduBusy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", MduBusy); end
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (!MduBusy) break;
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        ID_MduStart = 1;
        next_cycle();
        ID_MduStart = 0;
        ID_UsesHiLo = 1;
        @(negedge clk);
        checks += 2;
        if (MduBusy !== 1'b1) begin failures++; $display("FAIL rmb_busy1 got=%b exp=1", MduBusy); end
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL rmb_stall1 got=%b exp=0", PCWrite); end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (MduBusy !== 1'b0) begin failures++; $display("FAIL rmb_busy got=%b exp=0", MduBusy); end
        if (StallCycles !== 16'd0) begin failures++; $display("FAIL rmb_count got=%0d exp=0", StallCycles); end
        if (PCWrite !== 1'b1) begin failures++; $display("FAIL rmb_nostall got=%b exp=1", PCWrite); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            IFID_Rs       = 5'($urandom_range(0, 3));
            IFID_Rt       = 5'($urandom_range(0, 3));
            IDEX_Rd       = 5'($urandom_range(0, 3));
            EXMEM_Rd      = 5'($urandom_range(0, 3));
            ID_UsesRt     = 1'($urandom_range(0, 1));
            ID_IsBranch   = 1'($urandom_range(0, 1));
            ID_MduStart   = ($urandom_range(0, 3) == 0);
            ID_UsesHiLo   = ($urandom_range(0, 3) == 0);
            BranchTaken   = 1'($urandom_range(0, 1));
            IDEX_RegWrite = 1'($urandom_range(0, 1));
            IDEX_MemRead  = ($urandom_range(0, 2) == 0);
            EXMEM_MemRead = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            s = f_stall();
            checks += 6;
            if (PCWrite !== !s) begin failures++; $display("FAIL rnd_pcwrite i=%0d got=%b exp=%b", i, PCWrite, !s); end
            if (IFID_Write !== !s) begin failures++; $display("FAIL rnd_ifidwrite i=%0d got=%b exp=%b", i, IFID_Write, !s); end
            if (IDEX_Bubble !== s) begin failures++; $display("FAIL rnd_bubble i=%0d got=%b exp=%b", i, IDEX_Bubble, s); end
            if (IFID_Flush !== (BranchTaken && !s)) begin
                failures++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, IFID_Flush, BranchTaken && !s);
            end
            if (MduBusy !== (m_rem > 0)) begin
                failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, MduBusy, m_rem > 0);
            end
            if (int'(StallCycles) != m_cnt) begin
                failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, StallCycles, m_cnt);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        rst_n = 1'b1;
        IDEX_MemRead = 1; IDEX_Rd = 5; IFID_Rs = 5;
        repeat (70000) next_cycle();
        @(negedge clk);
        checks += 2;
        if (StallCycles !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", StallCycles); end
        if (PCWrite !== 1'b0) begin failures++; $display("FAIL sat_stall got=%b exp=0", PCWrite); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (StallCycles !== 16'hFFFF) begin failures++; $display("FAIL sat_nowrap got=%h exp=ffff", StallCycles); end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mdu();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
